// File: rtl/uart_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver_pkg
// Description : Shared FSM state encoding and bit-timing helpers for the
//               8N1 UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Rounded to the nearest whole clock so the bit period error stays below half a cycle.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic int calc_half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver with mid-bit sampling, valid/ready output,
//               frame-error pulse and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_27mhz,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    import uart_receiver_pkg::*;

    localparam int c_clks_per_bit = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int c_half_bit     = calc_half_bit(c_clks_per_bit);
    localparam int c_cnt_w        = (c_clks_per_bit > 2) ? $clog2(c_clks_per_bit) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_bit_last  = c_cnt_w'(c_clks_per_bit - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half_last = c_cnt_w'(c_half_bit - 1);

    logic               w_rx_s;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_overrun;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk_27mhz),
        .rst (rst),
        .i_d (uart_rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            // Handshake clears valid; a delivery on the same edge below takes priority.
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= 3'd0;
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_cnt_half_last) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_cnt_bit_last) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == c_cnt_bit_last) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                            if (!r_rx_valid || rx_ready) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver against a byte-level
//               reference model (expected-byte queue plus output-flag model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int c_bit = 234;

    logic       clk_27mhz = 1'b0;
    logic       rst       = 1'b1;
    logic       uart_rx   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready  = 1'b1;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         cmp_idx   = 0;
    int         valid_cyc = 0;
    int         fe_cyc    = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;

    uart_receiver #(
        .CLK_FREQ (27000000),
        .BAUD     (115200)
    ) dut (
        .clk_27mhz (clk_27mhz),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk_27mhz = ~clk_27mhz;

    // Observe away from the active edge: valid && ready here means a handshake on the next rising edge.
    always @(negedge clk_27mhz) begin
        if (rx_valid) valid_cyc++;
        if (frame_err) fe_cyc++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int k);
        uart_rx = 1'b1;
        repeat (k) @(posedge clk_27mhz);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int n);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (n) @(posedge clk_27mhz);
            #1;
        end
    endtask

    // Model of a well-formed frame completing at the receiver.
    task automatic model_deliver(input logic [7:0] d);
        if (!m_valid || rx_ready) begin
            m_data = d;
            m_valid = !rx_ready;
            if (rx_ready) exp_q.push_back(d);
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (cmp_idx < exp_q.size() && cmp_idx < got_q.size()) begin
            check({tag, "_byte"}, {24'h0, got_q[cmp_idx]}, {24'h0, exp_q[cmp_idx]});
            cmp_idx++;
        end
    endtask

    initial begin
        int v0, f0, n, d;

        repeat (3) @(posedge clk_27mhz);
        #1;
        rst = 1'b0;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        idle(20);

        // Single frame, consumer always ready
        v0 = valid_cyc; f0 = fe_cyc;
        send_frame(8'h55, 1'b1, c_bit); model_deliver(8'h55);
        idle(20);
        check_bytes("frame55");
        check("frame55_valid_cycles", valid_cyc - v0, 1);
        check("frame55_frame_err", fe_cyc - f0, 0);
        check("frame55_overrun", overrun, m_ovr);

        // Short low glitch must be rejected silently
        v0 = valid_cyc; f0 = fe_cyc;
        uart_rx = 1'b0;
        repeat (50) @(posedge clk_27mhz);
        #1;
        idle(400);
        check("glitch_no_valid", valid_cyc - v0, 0);
        check("glitch_no_frame_err", fe_cyc - f0, 0);

        // Bad stop bit, then line held low (break), then a good frame
        v0 = valid_cyc; f0 = fe_cyc;
        send_frame(8'hA5, 1'b0, c_bit);
        repeat (500) @(posedge clk_27mhz);
        #1;
        idle(300);
        check("break_frame_err_pulse", fe_cyc - f0, 1);
        check("break_no_valid", valid_cyc - v0, 0);
        send_frame(8'h3C, 1'b1, c_bit); model_deliver(8'h3C);
        idle(20);
        check_bytes("after_break");

        // Consumer stalled: second byte is dropped and overrun latches
        rx_ready = 1'b0;
        send_frame(8'h12, 1'b1, c_bit); model_deliver(8'h12);
        idle(10);
        send_frame(8'h34, 1'b1, c_bit); model_deliver(8'h34);
        idle(20);
        check("stall_rx_data", rx_data, m_data);
        check("stall_rx_valid", rx_valid, m_valid);
        check("stall_overrun", overrun, m_ovr);
        rx_ready = 1'b1;
        exp_q.push_back(m_data); m_valid = 1'b0;
        idle(5);
        check_bytes("drain");
        check("drain_rx_valid", rx_valid, 1'b0);
        check("overrun_sticky", overrun, 1'b1);

        // Reset in the middle of data bit 4 of 0xFF
        f0 = fe_cyc;
        uart_rx = 1'b0;
        repeat (c_bit) @(posedge clk_27mhz);
        #1;
        uart_rx = 1'b1;
        repeat (4 * c_bit + 100) @(posedge clk_27mhz);
        #1;
        rst = 1'b1;
        @(posedge clk_27mhz);
        #1;
        rst = 1'b0;
        m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        idle(6 * c_bit);
        check("midrst_no_frame_err", fe_cyc - f0, 0);
        check_bytes("midrst_no_delivery");
        send_frame(8'h81, 1'b1, c_bit); model_deliver(8'h81);
        idle(20);
        check_bytes("after_reset");

        // Ten back-to-back frames with alternating +/-2% bit period
        f0 = fe_cyc;
        for (int i = 0; i < 10; i++) begin
            n = (i % 2 == 0) ? 239 : 229;
            send_frame(8'(i), 1'b1, n); model_deliver(8'(i));
        end
        idle(20);
        check_bytes("burst");
        check("burst_no_frame_err", fe_cyc - f0, 0);
        check("burst_overrun", overrun, m_ovr);

        // Random bytes, random baud skew and inter-frame gaps
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 255);
            n = $urandom_range(229, 239);
            send_frame(8'(d), 1'b1, n); model_deliver(8'(d));
            idle($urandom_range(0, 40));
        end
        idle(20);
        check_bytes("random");
        check("final_rx_data", rx_data, m_data);
        check("final_frame_err", fe_cyc - f0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 SHALL have port clk_27mhz  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data  output  8  received byte, stable while rx_valid=1.
REQ-007 SHALL have port rx_valid  output  1  byte available.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts byte.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  sticky flag, completed byte dropped.

Function
REQ-011 SHALL pass uart_rx through a two-flop synchronizer (reset value 1) before any use; rx_s denotes its output.
REQ-012 SHALL use CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD (234 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (117).
REQ-013 SHALL implement states IDLE, START, DATA, STOP, BREAK with a bit-period counter and a 3-bit bit index.
REQ-014 IDLE: rx_s=0 -> START, counter cleared.
REQ-015 START: at counter = HALF_BIT-1 sample rx_s; 0 -> DATA, counter cleared; 1 -> IDLE (glitch rejected, no output activity).
REQ-016 DATA: at counter = CLKS_PER_BIT-1 shift rx_s into bit[index], counter cleared; after index 7 -> STOP.
REQ-017 STOP: at counter = CLKS_PER_BIT-1 sample rx_s; 1 -> deliver byte, IDLE; 0 -> frame_err=1 for that one cycle, byte discarded, BREAK.
REQ-018 BREAK: stay until rx_s=1, then IDLE.
REQ-019 Delivery SHALL load rx_data and set rx_valid on the same edge as the stop-bit sample.
REQ-020 rx_valid SHALL clear on the edge where rx_valid=1 and rx_ready=1, unless a delivery occurs on that edge.
REQ-021 Delivery with rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun set to 1 until rst.
REQ-022 Delivery with rx_valid=1 and rx_ready=1: new byte loaded, rx_valid stays 1, overrun unchanged.
REQ-023 rx_data SHALL NOT change while rx_valid=1 except per REQ-022.
REQ-024 Receiver SHALL keep sampling frames regardless of rx_valid/rx_ready; the line is never back-pressured.
REQ-025 The counter width SHALL be $clog2(CLKS_PER_BIT); it SHALL never wrap beyond CLKS_PER_BIT-1.

Reset
REQ-026 On rst=1 at a clock edge: state IDLE, counter 0, index 0, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-027 rst asserted mid-frame SHALL abandon the frame with no delivery and no frame_err; reception SHALL resume at the next falling edge after rst deasserts.

Structure
REQ-028 A shared package SHALL hold the state enumeration and the CLKS_PER_BIT/HALF_BIT computation functions.
REQ-029 The synchronizer SHALL be a sub-module named sync_2ff (parameterized reset value); everything else stays in uart_receiver.

Verification
REQ-030 Frame 0x55 at 115200, rx_ready=1 -> rx_data=0x55, rx_valid high exactly one cycle, frame_err=0, overrun=0.
REQ-031 uart_rx low for 50 cycles, then high -> no rx_valid, no frame_err, state back to IDLE.
REQ-032 Frame 0xA5 with stop bit low, line held low 500 cycles -> one frame_err pulse, no rx_valid; next frame 0x3C is received correctly.
REQ-033 Frames 0x12 then 0x34, rx_ready=0 -> rx_data=0x12 retained, rx_valid=1, overrun=1 after second stop bit.
REQ-034 rst pulsed during bit 4 of frame 0xFF -> all outputs at reset values; following frame 0x81 delivered as 0x81.
REQ-035 Ten back-to-back frames 0x00..0x09, rx_ready=1, baud offset +-2% -> all ten bytes in order, no errors.
